// File: rtl/alu_issue.sv
// alu_issue: instruction queue in front of a shift/arith ALU.
// Entries are accepted into a DEPTH-deep FIFO, then issued one per cycle to
// the ALU through registered outputs, gated by an IDLE/RUN/HOLD FSM that
// honours alu_stall. Illegal unit selects are dropped with an error pulse.
// Optional feature macro: ALU_ISSUE_BYPASS_EN (same-edge issue of a push into
// an empty idle queue). Default build has no bypass.
module alu_issue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opselect,
  input  logic [2:0]        in_operation,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic              alu_stall,
  output logic [DATA_W-1:0] aluin1,
  output logic [DATA_W-1:0] aluin2,
  output logic [2:0]        operation,
  output logic [2:0]        opselect,
  output logic              enable_arith,
  output logic              enable_shift,
  output logic              err_illegal,
  output logic [15:0]       issue_count
);

  localparam int ENTRY_W = 6 + 2 * DATA_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  // Only the shift (000) and arith (001) units exist.
  function automatic logic sel_legal(input logic [2:0] sel);
    sel_legal = (sel == 3'b000) || (sel == 3'b001);
  endfunction

  state_t              state_q, state_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [ENTRY_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [DATA_W-1:0]   aluin1_q, aluin1_d;
  logic [DATA_W-1:0]   aluin2_q, aluin2_d;
  logic [2:0]          operation_q, operation_d;
  logic [2:0]          opselect_q, opselect_d;
  logic                enable_arith_q, enable_arith_d;
  logic                enable_shift_q, enable_shift_d;
  logic                err_illegal_q, err_illegal_d;
  logic [15:0]         issue_count_q, issue_count_d;

  logic                full_s;
  logic                ready_s;
  logic                push_s;
  logic                pop_s;
  logic                bypass_s;
  logic                store_s;
  logic                issue_s;
  logic [ENTRY_W-1:0]  in_entry_s;
  logic [ENTRY_W-1:0]  head_s;
  logic [2:0]          head_sel_s;
  logic [2:0]          iss_sel_s;
  logic [2:0]          iss_op_s;
  logic [DATA_W-1:0]   iss_src1_s;
  logic [DATA_W-1:0]   iss_src2_s;

  // Handshake and pop/issue decisions; no pass-through, so a same-cycle pop
  // never lifts a full queue's ready.
  assign full_s     = (count_q == CNT_W'(DEPTH));
  assign ready_s    = !full_s && !reset;
  assign push_s     = in_valid && ready_s;
  assign pop_s      = (state_q == S_RUN) && !alu_stall;
  assign in_entry_s = {in_opselect, in_operation, in_src1, in_src2};
  assign head_s     = mem_q[rd_ptr_q];
  assign head_sel_s = head_s[ENTRY_W-1 -: 3];

`ifdef ALU_ISSUE_BYPASS_EN
  assign bypass_s = push_s && (count_q == '0) && !alu_stall && sel_legal(in_opselect);
`else
  assign bypass_s = 1'b0;
`endif

  assign store_s    = push_s && !bypass_s;
  assign issue_s    = (pop_s && sel_legal(head_sel_s)) || bypass_s;
  assign iss_sel_s  = bypass_s ? in_opselect  : head_sel_s;
  assign iss_op_s   = bypass_s ? in_operation : head_s[ENTRY_W-4 -: 3];
  assign iss_src1_s = bypass_s ? in_src1      : head_s[2*DATA_W-1 -: DATA_W];
  assign iss_src2_s = bypass_s ? in_src2      : head_s[DATA_W-1:0];

  // Next-state for queue storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (store_s) begin
      mem_d[wr_ptr_q] = in_entry_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({store_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state for the issue registers: load on issue, otherwise hold data and drop strobes.
  always_comb begin
    aluin1_d       = aluin1_q;
    aluin2_d       = aluin2_q;
    operation_d    = operation_q;
    opselect_d     = opselect_q;
    enable_arith_d = 1'b0;
    enable_shift_d = 1'b0;
    issue_count_d  = issue_count_q;
    err_illegal_d  = pop_s && !sel_legal(head_sel_s);
    if (issue_s) begin
      aluin1_d       = iss_src1_s;
      aluin2_d       = iss_src2_s;
      operation_d    = iss_op_s;
      opselect_d     = iss_sel_s;
      enable_arith_d = (iss_sel_s == 3'b001);
      enable_shift_d = (iss_sel_s == 3'b000);
      issue_count_d  = issue_count_q + 16'd1;
    end else begin
      issue_count_d  = issue_count_q;
    end
  end

  // FSM next state: an entry waits one edge in IDLE/HOLD before RUN may pop it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = alu_stall ? S_HOLD : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (alu_stall) begin
          state_d = S_HOLD;
        end else if (count_d == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_HOLD: begin
        if (alu_stall) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset clears everything asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      aluin1_q       <= '0;
      aluin2_q       <= '0;
      operation_q    <= 3'b000;
      opselect_q     <= 3'b000;
      enable_arith_q <= 1'b0;
      enable_shift_q <= 1'b0;
      err_illegal_q  <= 1'b0;
      issue_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      aluin1_q       <= aluin1_d;
      aluin2_q       <= aluin2_d;
      operation_q    <= operation_d;
      opselect_q     <= opselect_d;
      enable_arith_q <= enable_arith_d;
      enable_shift_q <= enable_shift_d;
      err_illegal_q  <= err_illegal_d;
      issue_count_q  <= issue_count_d;
    end
  end

  // Queue payload storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign in_ready     = ready_s;
  assign aluin1       = aluin1_q;
  assign aluin2       = aluin2_q;
  assign operation    = operation_q;
  assign opselect     = opselect_q;
  assign enable_arith = enable_arith_q;
  assign enable_shift = enable_shift_q;
  assign err_illegal  = err_illegal_q;
  assign issue_count  = issue_count_q;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_W, default 32, operand width of aluin1/aluin2 and in_src1/in_src2.
REQ-002 Parameter DEPTH, default 4, instruction queue entries; power of two, >=2.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream instruction offered.
REQ-006 in_ready  output  1  queue can accept; equals !full && !reset.
REQ-007 in_opselect  input  3  unit select: 3'b000 shift, 3'b001 arith, others illegal.
REQ-008 in_operation  input  3  operation code, passed through unchanged.
REQ-009 in_src1, in_src2  input  DATA_W  operands.
REQ-010 alu_stall  input  1  downstream ALU cannot take an issue this cycle.
REQ-011 aluin1, aluin2  output  DATA_W  registered operands to ALU.
REQ-012 operation, opselect  output  3  registered codes to ALU.
REQ-013 enable_arith, enable_shift  output  1  one-cycle issue strobes, mutually exclusive.
REQ-014 err_illegal  output  1  one-cycle pulse when an illegal opselect is dropped.
REQ-015 issue_count  output  16  number of issued instructions, wraps 16'hFFFF->0.

Function
REQ-016 Transfer occurs on a rising edge where in_valid && in_ready; entry pushed at queue tail.
REQ-017 Queue is FIFO-ordered; with DEPTH entries full, in_ready is 0; a same-cycle pop does not raise in_ready that cycle (no pass-through).
REQ-018 FSM states: IDLE (queue empty), RUN (queue non-empty, alu_stall=0), HOLD (queue non-empty, alu_stall=1).
REQ-019 Transitions: IDLE->RUN on push; RUN->HOLD when alu_stall=1; HOLD->RUN when alu_stall=0; RUN->IDLE when last entry pops with no push.
REQ-020 In RUN the head entry pops each edge; the output registers load its operands/codes and assert exactly one of enable_arith (opselect 001) or enable_shift (opselect 000) for one cycle.
REQ-021 A head entry with illegal opselect pops without issuing: enables stay 0, outputs hold previous values, err_illegal pulses one cycle, issue_count unchanged.
REQ-022 In HOLD or IDLE no pop occurs; enables are 0; aluin1/aluin2/operation/opselect hold last issued values.
REQ-023 Base latency: instruction accepted into empty queue at edge N issues (enable high) after edge N+2.
REQ-024 issue_count increments by 1 on every edge that asserts an enable; wraps modulo 2^16.
REQ-025 Simultaneous push and pop in RUN leaves occupancy unchanged; pointers wrap modulo DEPTH.
REQ-026 alu_stall asserted in the same cycle an enable is high does not cancel that issue; it blocks the next pop.

Reset
REQ-027 While reset=1: queue empty, FSM IDLE, in_ready=0, all other outputs 0, issue_count=0, asynchronously.
REQ-028 Reset asserted mid-operation discards all queued entries; no enable asserts on the first edge after release.
REQ-029 in_ready rises to 1 combinationally when reset deasserts.

Configuration
REQ-030 Macro ALU_ISSUE_BYPASS_EN defined: a push into an empty queue in IDLE with alu_stall=0 and legal opselect issues at that same edge (latency 1), entry not stored.
REQ-031 ALU_ISSUE_BYPASS_EN undefined: no bypass; REQ-023 latency applies in all cases.

Verification
REQ-032 Reset release, push {sel=001,op=3'b010,src1=5,src2=7} -> enable_arith=1 two cycles later with aluin1=5, aluin2=7, issue_count=1 (one cycle with bypass).
REQ-033 alu_stall=1, push 5 entries -> in_ready=0 after 4th; 5th held; release stall -> 4 issues on consecutive cycles in push order, then 5th accepted.
REQ-034 Push sel=3'b111 between two legal shifts -> err_illegal one pulse, only 2 enable_shift strobes, issue_count=2.
REQ-035 Preload issue_count to 16'hFFFF by issuing 65535 ops, issue one more -> issue_count=0.
REQ-036 Assert reset with 3 entries queued and stall=1 -> all outputs 0 immediately; after release no enable without new push.
REQ-037 Continuous push at full rate, alu_stall=0 -> one enable per cycle, occupancy constant, no drops.
